// File: rtl/data_mem_loader.sv
// -----------------------------------------------------------------------------
// data_mem_loader
//
// Fill stage for the dual-read data memory pair. Accepts a byte stream over a
// valid/ready handshake, packs bytes little-endian into DATA_WIDTH words and
// drives the shared memory write port with an auto-incrementing address.
// Used to preload data memory from a host link before the CPU is released,
// and to reload tables at run time while the CPU is held.
//
// Optional feature macro: DATA_MEM_LOADER_CHECKSUM_EN
//   defined     -> checksum is the 16-bit wrapping sum of every accepted byte
//                  of the current/last load (cleared when a load starts)
//   not defined -> checksum is tied to zero
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        one-cycle load request, honoured only when idle
//   start_addr   first word address of the load
//   word_count   number of words to load (0 allowed, clamps to 2^ADDR_WIDTH)
//   in_data      stream byte
//   in_valid     stream byte available
//   in_ready     loader takes the byte this cycle
//   mem_addr_w   memory write address
//   mem_data_in  memory write data
//   mem_we       memory write enable (one cycle per assembled word)
//   busy         load in progress
//   done         one-cycle pulse when the load completes
//   checksum     byte sum of the current/last load
// -----------------------------------------------------------------------------
module data_mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr_w,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           checksum
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(BYTES - 1);
    localparam logic [LANE_W-1:0]   LANE_ONE  = LANE_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_ZERO  = (ADDR_WIDTH + 1)'(0);
    localparam logic [ADDR_WIDTH:0] CNT_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Requests larger than the whole address space are cut to one full pass.
    function automatic logic [ADDR_WIDTH:0] clamp_count(input logic [ADDR_WIDTH:0] cnt);
        logic [ADDR_WIDTH:0] res;
        if (cnt > CNT_MAX) begin
            res = CNT_MAX;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    state_t                  state_d,       state_q;
    logic [ADDR_WIDTH-1:0]   addr_d,        addr_q;
    logic [ADDR_WIDTH:0]     remaining_d,   remaining_q;
    logic [LANE_W-1:0]       lane_d,        lane_q;
    logic [DATA_WIDTH-1:0]   word_d,        word_q;
    logic                    in_ready_d,    in_ready_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_w_d,  mem_addr_w_q;
    logic [DATA_WIDTH-1:0]   mem_data_in_d, mem_data_in_q;
    logic                    mem_we_d,      mem_we_q;
    logic                    busy_d,        busy_q;
    logic                    done_d,        done_q;

    logic                    start_acc_s;
    logic                    byte_acc_s;
    logic [ADDR_WIDTH:0]     count_clamped_s;

    assign start_acc_s     = (state_q == ST_IDLE) && start;
    assign byte_acc_s      = (state_q == ST_RECV) && in_valid && in_ready_q;
    assign count_clamped_s = clamp_count(word_count);

    // Next-state, counters, word assembly and next values of the registered outputs.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        lane_d        = lane_q;
        word_d        = word_q;
        mem_addr_w_d  = mem_addr_w_q;
        mem_data_in_d = mem_data_in_q;
        in_ready_d    = 1'b0;
        mem_we_d      = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_acc_s) begin
                    addr_d      = start_addr;
                    remaining_d = count_clamped_s;
                    lane_d      = {LANE_W{1'b0}};
                    if (count_clamped_s != CNT_ZERO) begin
                        state_d = ST_RECV;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (byte_acc_s) begin
                    // Drop the byte into its lane; other lanes keep their bytes.
                    for (int i = 0; i < BYTES; i++) begin
                        word_d[8*i +: 8] = (lane_q == LANE_W'(i)) ? in_data : word_q[8*i +: 8];
                    end
                    if (lane_q == LAST_LANE) begin
                        lane_d        = {LANE_W{1'b0}};
                        state_d       = ST_WRITE;
                        mem_addr_w_d  = addr_q;
                        mem_data_in_d = word_d;
                    end else begin
                        lane_d  = lane_q + LANE_ONE;
                        state_d = ST_RECV;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_WRITE: begin
                // Address wraps naturally at 2^ADDR_WIDTH.
                addr_d      = addr_q + ADDR_ONE;
                remaining_d = remaining_q - CNT_ONE;
                if (remaining_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        in_ready_d = (state_d == ST_RECV);
        mem_we_d   = (state_d == ST_WRITE);
        busy_d     = (state_d == ST_RECV) || (state_d == ST_WRITE);
        done_d     = (state_d == ST_DONE);
    end

    // State, counters, word buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= {ADDR_WIDTH{1'b0}};
            remaining_q   <= {(ADDR_WIDTH + 1){1'b0}};
            lane_q        <= {LANE_W{1'b0}};
            word_q        <= {DATA_WIDTH{1'b0}};
            in_ready_q    <= 1'b0;
            mem_addr_w_q  <= {ADDR_WIDTH{1'b0}};
            mem_data_in_q <= {DATA_WIDTH{1'b0}};
            mem_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            lane_q        <= lane_d;
            word_q        <= word_d;
            in_ready_q    <= in_ready_d;
            mem_addr_w_q  <= mem_addr_w_d;
            mem_data_in_q <= mem_data_in_d;
            mem_we_q      <= mem_we_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

`ifdef DATA_MEM_LOADER_CHECKSUM_EN
    logic [15:0] checksum_d, checksum_q;

    // Running byte sum, restarted by an accepted start.
    always_comb begin
        checksum_d = checksum_q;
        if (start_acc_s) begin
            checksum_d = 16'h0000;
        end else if (byte_acc_s) begin
            checksum_d = checksum_q + {8'h00, in_data};
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= 16'h0000;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign in_ready    = in_ready_q;
    assign mem_addr_w  = mem_addr_w_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_we      = mem_we_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_data_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_data_mem_loader
//
// Self-checking bench for data_mem_loader. Loads are described as a start
// address, a word count and a byte list; the expected write list, latencies
// and checksum come from a plain arithmetic model of the load rules.
// -----------------------------------------------------------------------------
module tb_data_mem_loader;

    localparam int BYTES = 4;
    localparam int AW    = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] start_addr;
    logic [12:0] word_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] mem_addr_w;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    data_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .word_count  (word_count),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mem_addr_w  (mem_addr_w),
        .mem_data_in (mem_data_in),
        .mem_we      (mem_we),
        .busy        (busy),
        .done        (done),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int we_cnt  = 0;
    int rdy_cnt = 0;

    logic [11:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    logic [7:0]  bq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // write-port monitor
    always @(negedge clk) begin
        if (mem_we) begin
            obs_addr.push_back(mem_addr_w);
            obs_data.push_back(mem_data_in);
            obs_cyc.push_back(cyc);
            we_cnt <= we_cnt + 1;
            check("we_while_busy", busy, 1);
        end
        if (in_ready) rdy_cnt <= rdy_cnt + 1;
    end

    task automatic fill_rand(input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(8'($urandom_range(0, 255)));
    endtask

    function automatic logic [31:0] model_word(input int w);
        logic [31:0] d;
        d = 32'h0;
        for (int b = 0; b < BYTES; b++) d = d | (32'(bq[BYTES*w + b]) << (8*b));
        return d;
    endfunction

    function automatic logic [15:0] model_sum(input int n);
        int s;
        s = 0;
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
        for (int i = 0; i < n; i++) s = s + int'(bq[i]);
`endif
        return 16'(s % 65536);
    endfunction

    // One complete load: start pulse, byte feed with optional gaps, optional
    // ignored re-start, then comparison of writes, timing and checksum.
    task automatic run_load(input int sa, input int wc, input int gap, input bit restart);
        int eff, n, idx, t, w, start_cyc, done_cyc;
        bit acc, restarted;
        eff = (wc > (1 << AW)) ? (1 << AW) : wc;
        n   = eff * BYTES;
        @(negedge clk);
        check("done_is_pulse", done, 0);
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        start = 1'b1; start_addr = sa[11:0]; word_count = wc[12:0];
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", busy, (eff > 0));
        check("ready_after_start", in_ready, (eff > 0));
        check("done_after_start", done, (eff == 0));
        idx = 0; t = 0; restarted = 1'b0;
        while (idx < n && t < n*4 + 100) begin
            if (restart && idx == 5 && !restarted) begin
                start = 1'b1; start_addr = 12'h555; word_count = 13'd7; restarted = 1'b1;
            end else begin
                start = 1'b0;
            end
            in_valid = ((t % gap) == 0);
            in_data  = bq[idx];
            acc = in_valid && in_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) idx++;
            t++;
        end
        start = 1'b0; in_valid = 1'b0;
        if (idx < n) check("feed_timeout", idx, n);
        w = 0;
        while (!done && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("done_seen", done, 1);
        done_cyc = cyc;
        check("busy_low_at_done", busy, 0);
        check("checksum", checksum, model_sum(n));
        check("write_count", obs_addr.size(), eff);
        for (int i = 0; i < eff && i < obs_addr.size(); i++) begin
            check("write_addr", obs_addr[i], (sa + i) % (1 << AW));
            check("write_data", obs_data[i], model_word(i));
        end
        if (eff > 0 && obs_cyc.size() == eff)
            check("done_latency", done_cyc, obs_cyc[eff-1] + 1);
        if (gap == 1 && obs_cyc.size() == eff && eff > 0) begin
            check("first_write_latency", obs_cyc[0], start_cyc + BYTES);
            for (int i = 1; i < eff; i++)
                check("word_spacing", obs_cyc[i] - obs_cyc[i-1], BYTES + 1);
        end
    endtask

    initial begin
        int r0, w0, cnt;
        reset = 1'b1; start = 1'b0; start_addr = 12'h0; word_count = 13'h0;
        in_data = 8'h0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_addr_w", mem_addr_w, 0);
        check("rst_mem_data_in", mem_data_in, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_checksum", checksum, 0);
        reset = 1'b0;

        // idle: valid bytes without a start are never taken
        @(negedge clk);
        r0 = rdy_cnt; w0 = we_cnt;
        in_valid = 1'b1; in_data = 8'hA5;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_no_ready", rdy_cnt - r0, 0);
        check("idle_no_write", we_cnt - w0, 0);

        // fixed two-word load
        bq.delete();
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load(12'h010, 2, 1, 1'b0);

        // address wrap
        fill_rand(8);
        run_load(12'hFFF, 2, 1, 1'b0);

        // zero-length load
        bq.delete();
        run_load(12'h123, 0, 1, 1'b0);

        // gapless and gapped runs with the same bytes, second one re-started mid-load
        fill_rand(12);
        run_load(12'h100, 3, 1, 1'b0);
        run_load(12'h100, 3, 3, 1'b1);

        // reset after two bytes of a word
        @(negedge clk);
        w0 = we_cnt;
        start = 1'b1; start_addr = 12'h030; word_count = 13'd1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
        @(negedge clk);
        in_data = 8'hBB;
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_in_ready", in_ready, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_mem_we", mem_we, 0);
        @(negedge clk);
        check("rst_mid_still_idle", in_ready, 0);
        check("rst_mid_no_write", we_cnt - w0, 0);
        fill_rand(4);
        run_load(12'h020, 1, 1, 1'b0);

        // random loads
        for (int k = 0; k < 6; k++) begin
            cnt = $urandom_range(1, 5);
            fill_rand(cnt * BYTES);
            run_load($urandom_range(0, 4095), cnt, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end

        // oversize count clamps to a full address-space pass
        fill_rand((1 << AW) * BYTES);
        run_load($urandom_range(0, 4095), (1 << AW) + 1, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
